// File: rtl/lock_key_conditioner.sv
// Conditions two raw push-buttons into single-cycle key pulses for the lock detector:
// 2-flop sync, press/release debounce, conflict rejection and an inactivity timeout.
module lock_key_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 64,
    parameter int unsigned CNT_W           = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic btn0_raw,
    input  logic btn1_raw,
    output logic inp0,
    output logic inp1,
    output logic key_err,
    output logic entry_clr,
    output logic busy
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS_DB = 3'd1,
        HELD     = 3'd2,
        CONFLICT = 3'd3,
        REL_DB   = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       sync0, sync1;
    logic [1:0]       p;
    logic [1:0]       key, key_nxt;
    logic [CNT_W-1:0] dcnt, dcnt_nxt;
    logic [CNT_W-1:0] tcnt, tcnt_nxt;
    logic             armed, armed_nxt;
    logic             inp0_nxt, inp1_nxt, key_err_nxt, entry_clr_nxt;

    // Synchronised pattern {s1,s0}; bit [1] of each chain is the settled sample.
    assign p    = {sync1[1], sync0[1]};
    assign busy = (state != IDLE);

    // State register, debounce/timeout datapath and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync0     <= '0;
            sync1     <= '0;
            state     <= IDLE;
            key       <= '0;
            dcnt      <= '0;
            tcnt      <= '0;
            armed     <= 1'b0;
            inp0      <= 1'b0;
            inp1      <= 1'b0;
            key_err   <= 1'b0;
            entry_clr <= 1'b0;
        end else begin
            sync0     <= {sync0[0], btn0_raw};
            sync1     <= {sync1[0], btn1_raw};
            state     <= state_nxt;
            key       <= key_nxt;
            dcnt      <= dcnt_nxt;
            tcnt      <= tcnt_nxt;
            armed     <= armed_nxt;
            inp0      <= inp0_nxt;
            inp1      <= inp1_nxt;
            key_err   <= key_err_nxt;
            entry_clr <= entry_clr_nxt;
        end
    end

    // Next-state: press and release both need DEBOUNCE_CYCLES+1 matching samples.
    always_comb begin
        state_nxt = state;
        key_nxt   = key;
        dcnt_nxt  = dcnt;
        unique case (state)
            IDLE: begin
                if (p == 2'b11) begin
                    state_nxt = CONFLICT;
                end else if (p != 2'b00) begin
                    key_nxt   = p;
                    dcnt_nxt  = '0;
                    state_nxt = PRESS_DB;
                end
            end
            PRESS_DB: begin
                if (p == key) begin
                    if (dcnt == DB_LAST) state_nxt = HELD;
                    else                 dcnt_nxt  = dcnt + CNT_W'(1);
                end else if (p == 2'b00) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = CONFLICT;
                end
            end
            HELD, CONFLICT: begin
                if (p == 2'b00) begin
                    dcnt_nxt  = '0;
                    state_nxt = REL_DB;
                end
            end
            REL_DB: begin
                if (p != 2'b00)          state_nxt = HELD;
                else if (dcnt == DB_LAST) state_nxt = IDLE;
                else                      dcnt_nxt  = dcnt + CNT_W'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output pulses and timeout; a key pulse re-arms ahead of a same-cycle expiry.
    always_comb begin
        inp0_nxt      = 1'b0;
        inp1_nxt      = 1'b0;
        key_err_nxt   = 1'b0;
        entry_clr_nxt = 1'b0;
        tcnt_nxt      = tcnt;
        armed_nxt     = armed;
        if (state == IDLE && p == 2'b11) begin
            key_err_nxt = 1'b1;
        end
        if (state == PRESS_DB && p != 2'b00 && p != key) begin
            key_err_nxt = 1'b1;
        end
        if (state == PRESS_DB && p == key && dcnt == DB_LAST) begin
            inp0_nxt = key[0];
            inp1_nxt = key[1];
        end
        if (inp0_nxt || inp1_nxt) begin
            tcnt_nxt  = '0;
            armed_nxt = 1'b1;
        end else if (armed) begin
            if (tcnt == TO_LAST) begin
                entry_clr_nxt = 1'b1;
                armed_nxt     = 1'b0;
                tcnt_nxt      = '0;
            end else begin
                tcnt_nxt = tcnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/lock_key_conditioner.md
Name: lock_key_conditioner

Overview:
Front-end stage that feeds the digital lock sequence detector. It takes two raw, bouncy, asynchronous push-buttons, synchronises and debounces them, and emits exactly one single-cycle `inp0` or `inp1` pulse per accepted press. Simultaneous presses are rejected and flagged. An inactivity timeout emits `entry_clr` so a partly entered code can be discarded downstream.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a press or release; legal range >=2
TIMEOUT_CYCLES, 64, cycles with no accepted key, after an armed key, before `entry_clr` fires; legal range >=2
CNT_W, 8, width of the debounce and timeout counters; must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, TIMEOUT_CYCLES)

Ports:
clock  in  1  system clock; all logic is on the rising edge
reset  in  1  asynchronous, active-low reset; reset is asserted when `reset` = 0
btn0_raw  in  1  raw button 0, asynchronous, active-high
btn1_raw  in  1  raw button 1, asynchronous, active-high
inp0  out  1  one-cycle pulse when a press of button 0 is accepted
inp1  out  1  one-cycle pulse when a press of button 1 is accepted
key_err  out  1  one-cycle pulse when both buttons are seen high together
entry_clr  out  1  one-cycle inactivity-timeout pulse
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (`reset` = 0, asynchronous):
  - Both synchroniser chains and all counters go to 0.
  - FSM goes to IDLE; the timeout is disarmed.
  - All outputs are 0.
  - Reset asserted mid-operation aborts immediately. No pulse is emitted on or after release of reset.
- Synchroniser: 2-flop chain per button, giving `s0`/`s1`. A raw high sampled at edge k is visible in `s*` after edge k+1.
- Pattern `P` = {s1,s0}. All outputs are registered.
- FSM states: IDLE, PRESS_DB, HELD, CONFLICT, REL_DB.
  - IDLE:
    - P=01 or P=10: capture the key id, clear `dcnt`, go to PRESS_DB.
    - P=11: go to CONFLICT and pulse `key_err`.
    - P=00: stay in IDLE.
  - PRESS_DB:
    - P equals the captured key: `dcnt` increments.
    - When `dcnt` = DEBOUNCE_CYCLES-1 and P still matches: go to HELD and pulse `inp0` or `inp1` at the same edge.
    - P=00: return to IDLE with no pulse.
    - P=11, or the other single key appears: go to CONFLICT and pulse `key_err`.
  - HELD:
    - Wait for P=00, then clear `dcnt` and go to REL_DB.
    - Pressing the other key while held emits nothing and raises no error (rollover is ignored).
  - CONFLICT:
    - Behaves like HELD, but no key pulse is ever produced.
    - On P=00, go to REL_DB.
  - REL_DB:
    - P=00: `dcnt` increments. When `dcnt` = DEBOUNCE_CYCLES-1, go to IDLE.
    - Any P≠00: return to HELD with no pulse. Release bounce never causes a second pulse.
- Latency: a raw press sampled at edge k and held stable gives a pulse high for exactly the one cycle after edge k+2+DEBOUNCE_CYCLES.
- Exclusivity: `inp0`, `inp1` and `key_err` are mutually exclusive. At most one is high in any cycle.
- Timeout counter `tcnt`:
  - A key pulse (`inp0` or `inp1`) clears `tcnt` and arms the timeout. This takes priority over expiry in the same cycle.
  - While armed, `tcnt` increments every cycle.
  - When `tcnt` reaches TIMEOUT_CYCLES-1: pulse `entry_clr`, disarm, clear `tcnt`.
  - While disarmed, `tcnt` holds at 0.
  - `key_err` does not arm the timeout and does not reset it.
- `busy` is combinational from the state register: `busy` = (state ≠ IDLE).

Test Plan:
1. Reset, then hold `btn0_raw` high from edge 10 for 20 cycles, then release → `inp0` high only in the cycle after edge 16. `inp1`=0 and `key_err`=0 throughout. FSM back in IDLE 4 stable-low cycles after `s0` falls.
2. Bounce on `btn1_raw`: 1,0,1,1,0 cycle by cycle, then steady 1 for 10 cycles, then bounce on release → exactly one `inp1` pulse, emitted 4 cycles after the steady-1 run reaches the FSM. No second pulse on release.
3. `btn0_raw` and `btn1_raw` rise at the same edge and are held for 10 cycles → one `key_err` pulse. No `inp0`/`inp1`. The block returns to IDLE after release plus 4 cycles.
4. Press button 0 (`inp0` fires), then press button 1 while button 0 is still held → no `inp1` and no `key_err`. After both are released, a fresh button-1 press gives an `inp1` pulse.
5. One accepted key, then no input → `entry_clr` pulses exactly 64 cycles after the `inp0` cycle, once only. A further 200 idle cycles produce no further pulse.
6. Assert `reset`=0 during PRESS_DB at `dcnt`=2, and again 10 cycles before the timeout expires → no pulses during or after reset; `busy`=0; `entry_clr` never fires.
